// File: rtl/fc_requant_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_requant_stream_if
// Brief    : Frame capture + element stream handshake bundle for fc_requant_stream.
// Revision : 1.0
// ============================================================================
interface fc_requant_stream_if #(
    parameter int WIDTH = 8,
    parameter int N     = 84,
    parameter int ACC_W = WIDTH*2+7
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [ACC_W-1:0]     in_data [0:N-1];
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_last;
    logic                 busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

`default_nettype wire

// File: rtl/fc_requant_stream.sv
`default_nettype none
// ============================================================================
// Module   : fc_requant_stream
// Brief    : Captures a frame of N accumulators, requantizes (round-half-up,
//            saturate) and streams them out one per cycle.
// Revision : 1.0
// ============================================================================
module fc_requant_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 84,
    parameter int ACC_W = WIDTH*2+7,
    parameter int SHIFT = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    fc_requant_stream_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = $clog2(N + 1);

    // Half-LSB rounding constant; collapses to zero when SHIFT is 0.
    localparam logic [ACC_W:0] C_RND = ((ACC_W+1)'(1) << SHIFT) >> 1;
    localparam logic [ACC_W:0] C_MAX = (ACC_W+1)'((1 << (WIDTH-1)) - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ACC_W-1:0]     r_frame [0:N-1];
    logic [PTR_W-1:0]     r_rd_ptr;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic [IDX_W-1:0]     r_out_idx;
    logic                 r_out_last;

    logic                 w_in_ready;
    logic                 w_busy;
    logic                 w_capture;
    logic                 w_load;
    logic                 w_accept;
    logic [ACC_W-1:0]     w_sel;
    logic [ACC_W:0]       w_sum;
    logic [ACC_W:0]       w_shr;
    logic [WIDTH-1:0]     w_rq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_busy = 1'b1;
                if (w_accept && r_out_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_capture = (r_state == ST_IDLE) && bus.in_valid;
    assign w_accept  = r_out_valid && bus.out_ready;
    assign w_load    = (r_state == ST_STREAM) && (r_rd_ptr < PTR_W'(N))
                       && (!r_out_valid || bus.out_ready);

    // Requantizer: one extra headroom bit so the rounding add cannot wrap.
    assign w_sel = r_frame[r_rd_ptr[IDX_W-1:0]];
    assign w_sum = {1'b0, w_sel} + C_RND;
    assign w_shr = w_sum >> SHIFT;

    always_comb begin
        w_rq = '0;
        if (!w_sel[ACC_W-1]) begin
            if (w_shr > C_MAX) begin
                w_rq = C_MAX[WIDTH-1:0];
            end else begin
                w_rq = w_shr[WIDTH-1:0];
            end
        end
    end

    // Frame storage carries no reset; it is only read after a capture.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_frame <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_capture) begin
            r_rd_ptr <= '0;
        end else if (r_state == ST_STREAM) begin
            if (w_load) begin
                r_out_data  <= w_rq;
                r_out_idx   <= r_rd_ptr[IDX_W-1:0];
                r_out_last  <= (r_rd_ptr == PTR_W'(N-1));
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_fc_requant_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_requant_stream
// Brief    : Directed-vector self-checking bench for fc_requant_stream.
// Revision : 1.0
// ============================================================================
module tb_fc_requant_stream;
    localparam int WIDTH = 8;
    localparam int N     = 84;
    localparam int ACC_W = WIDTH*2+7;
    localparam int SHIFT = 7;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int VEC_W = 2 + IDX_W + WIDTH;

    logic clk;
    logic rst_n;

    fc_requant_stream_if #(.WIDTH(WIDTH), .N(N), .ACC_W(ACC_W)) bus ();

    fc_requant_stream #(.WIDTH(WIDTH), .N(N), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [ACC_W-1:0] fr    [0:N-1];
    logic [WIDTH-1:0] exp_d [0:N-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rq_model(input logic [ACC_W-1:0] v);
        longint t;
        if (v[ACC_W-1]) return '0;
        t = longint'(v) + ((SHIFT > 0) ? (longint'(1) << (SHIFT-1)) : 0);
        t = t >> SHIFT;
        if (t > (longint'(1) << (WIDTH-1)) - 1) t = (longint'(1) << (WIDTH-1)) - 1;
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [VEC_W-1:0] obs_vec();
        return {bus.out_valid, bus.out_last, bus.out_idx, bus.out_data};
    endfunction

    function automatic logic [VEC_W-1:0] exp_vec(input int k);
        return {1'b1, (k == N-1), IDX_W'(k), exp_d[k]};
    endfunction

    task automatic apply_frame();
        for (int i = 0; i < N; i++) bus.in_data[i] = fr[i];
    endtask

    task automatic model_exp();
        for (int i = 0; i < N; i++) exp_d[i] = rq_model(fr[i]);
    endtask

    // Consume one frame, comparing each element in order against exp_d.
    // mode 0: ready high except a stall of stall_len cycles on stall_idx;
    // mode 1: random ready.
    task automatic drain(input int mode, input int stall_idx, input int stall_len,
                         output int cycles, output int first);
        int   nxt;
        int   sc;
        bit   held;
        bit   done;
        bit   ir_bad;
        logic rdy;
        nxt = 0; sc = 0; held = 0; done = 0; ir_bad = 0;
        cycles = 0; first = -1;
        while (!done && cycles < 2000) begin
            if (held) begin
                check("hold", obs_vec(), exp_vec(nxt-1));
            end else if (bus.out_valid) begin
                if (first < 0) first = cycles;
                if (nxt >= N) begin
                    check("extra_elem", 64'(nxt), 64'(N-1));
                end else begin
                    check("elem", obs_vec(), exp_vec(nxt));
                end
                nxt++;
            end
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) ir_bad = 1;
            if (mode == 0) begin
                rdy = 1'b1;
                if (bus.out_valid && (nxt-1 == stall_idx) && sc < stall_len) begin
                    rdy = 1'b0;
                    sc++;
                end
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            bus.out_ready = rdy;
            held = bus.out_valid && !rdy;
            if (bus.out_valid && rdy && bus.out_last) done = 1;
            tick();
            cycles++;
        end
        if (!done) check("drain_timeout", 64'(0), 64'(1));
        check("elem_count", 64'(nxt), 64'(N));
        check("in_ready_during_stream", 64'(ir_bad), 64'(0));
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int first;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) bus.in_data[i] = '0;
        repeat (3) tick();
        check("rst_outputs", obs_vec(), '0);
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_busy", 64'(bus.busy), 64'(0));
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("post_rst_busy", 64'(bus.busy), 64'(0));

        // Requant values + cycle timing, ready held high.
        for (int i = 0; i < N; i++) fr[i] = 23'd191;
        fr[0] = 23'd0; fr[1] = 23'd63; fr[2] = 23'd64; fr[3] = 23'd200;
        fr[4] = 23'd16383; fr[5] = 23'h7FFFFF;
        apply_frame();
        for (int i = 0; i < N; i++) exp_d[i] = 8'd1;
        exp_d[0] = 8'd0; exp_d[1] = 8'd0; exp_d[2] = 8'd1; exp_d[3] = 8'd2;
        exp_d[4] = 8'd127; exp_d[5] = 8'd0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("cap_busy", 64'(bus.busy), 64'(1));
        check("cap_in_ready", 64'(bus.in_ready), 64'(0));
        check("cap_out_valid", 64'(bus.out_valid), 64'(0));
        drain(0, -1, 0, cyc, first);
        check("t1_first_valid", 64'(first), 64'(1));
        check("t1_frame_cycles", 64'(cyc), 64'(N+1));
        check("t1_end_in_ready", 64'(bus.in_ready), 64'(1));
        check("t1_end_busy", 64'(bus.busy), 64'(0));
        check("t1_end_out_valid", 64'(bus.out_valid), 64'(0));

        // Back-to-back capture, then backpressure on element 10.
        for (int i = 0; i < N; i++) begin
            fr[i]    = ACC_W'(i * 128);
            exp_d[i] = WIDTH'(i);
        end
        apply_frame();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("t2_cap_busy", 64'(bus.busy), 64'(1));
        drain(0, 10, 3, cyc, first);
        check("t2_first_valid", 64'(first), 64'(1));
        check("t2_frame_cycles", 64'(cyc), 64'(N+1+3));

        // in_valid held high with a different frame during STREAM.
        for (int i = 0; i < N; i++) fr[i] = ACC_W'(i * 3 + 5);
        apply_frame();
        model_exp();
        bus.in_valid = 1'b1;
        tick();
        for (int i = 0; i < N; i++) fr[i] = ACC_W'(16383 - i * 150);
        apply_frame();
        drain(0, -1, 0, cyc, first);
        check("t3a_frame_cycles", 64'(cyc), 64'(N+1));
        check("t3_idle_in_ready", 64'(bus.in_ready), 64'(1));
        model_exp();
        tick();
        bus.in_valid = 1'b0;
        check("t3b_cap_busy", 64'(bus.busy), 64'(1));
        drain(0, -1, 0, cyc, first);
        check("t3b_frame_cycles", 64'(cyc), 64'(N+1));

        // Reset pulse while element 40 is presented.
        for (int i = 0; i < N; i++) fr[i] = ACC_W'(i * 200 + 1);
        apply_frame();
        model_exp();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (41) tick();
        check("t4_at_idx40", obs_vec(), exp_vec(40));
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_clear", obs_vec(), '0);
        check("t4_rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("t4_rst_busy", 64'(bus.busy), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) fr[i] = ACC_W'(8000 + i * 97);
        apply_frame();
        model_exp();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("t4_recap_busy", 64'(bus.busy), 64'(1));
        drain(0, -1, 0, cyc, first);
        check("t4_frame_cycles", 64'(cyc), 64'(N+1));

        // Random ready over several frames with mixed-range values.
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       fr[i] = ACC_W'($urandom_range(0, 255));
                    1:       fr[i] = ACC_W'($urandom_range(0, 16383));
                    2:       fr[i] = ACC_W'($urandom_range(0, 32'h3FFFFF));
                    default: fr[i] = ACC_W'($urandom_range(0, 127) * 128 + 63 + $urandom_range(0, 1));
                endcase
            end
            apply_frame();
            model_exp();
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            drain(1, -1, 0, cyc, first);
            check("rnd_end_in_ready", 64'(bus.in_ready), 64'(1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
